debounce_scheduler: RTL
=======================

# debounce_scheduler

Multi-channel switch debouncer that shares one sample-rate prescaler across `NumCh` inputs and serialises their edge events. Each channel keeps a small stable-sample counter instead of a full-rate timer. Debounced edges queue as per-channel pending events, and a round-robin arbiter presents them one at a time on a valid/ready port. It sits between board switches/buttons and the control logic that consumes button events.

## Interface
- `NumCh`, 4: number of switch channels, 1..16.
- `ClkFreq`, 100_000_000: clock frequency in Hz.
- `SampleRate`, 1000: sample strobe rate in Hz. `SampleDiv = ClkFreq/SampleRate`, and `SampleDiv` must be ≥2 (checked by an elaboration assertion).
- `StableSamples`, 10: consecutive differing samples required to accept a new level, 1..255.
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  reset, asynchronous assert, active-low.
- `en_i`  in  1  sampling enable.
- `sw_i`  in  NumCh  raw asynchronous switch inputs.
- `db_level_o`  out  NumCh  debounced levels.
- `evt_valid_o`  out  1  event available.
- `evt_ready_i`  in  1  consumer accepts event.
- `evt_id_o`  out  max(1,$clog2(NumCh))  channel index of the event.
- `evt_rise_o`  out  1  1 = rising edge, 0 = falling edge.
- `overflow_o`  out  NumCh  sticky: an event was overwritten before it was granted.
- `ovf_clr_i`  in  1  clears all `overflow_o` bits.

## Operation
- **Synchroniser.** Each `sw_i` bit passes through a 2-flop synchroniser (`sync`).
- **Prescaler.** Counts 0..SampleDiv-1. `strobe` is 1 for the single cycle where count == SampleDiv-1.
  - When `en_i`=0, the count is held at 0, no strobes fire, and all channel counters clear.
  - Levels and pending events are unaffected by `en_i`, and the arbiter keeps draining.
- **Channel counter, per channel, on a strobe cycle:**
  - If `sync` == level, the counter clears.
  - Otherwise the counter increments. When it reaches StableSamples, level <= `sync`, the counter clears, and an event is pended with rise = new level.
- **Pending slot.** One slot per channel: a pending bit plus a rise bit.
  - New event into an empty slot: the slot is set.
  - New event into an occupied slot: the rise bit is overwritten with the newest value, and `overflow_o[ch]` is set.
  - Slot granted in the same cycle a new event arrives: the granted data goes to the output, the new event stays pending, and no overflow is flagged.
- **Arbiter FSM.**
  - IDLE: if any slot is pending, choose the first pending channel at or after `last+1` (mod NumCh). Load `evt_id_o` and `evt_rise_o`, clear that slot, set `last` = chosen, assert `evt_valid_o`, go to HOLD.
  - HOLD: outputs stay stable. When `evt_valid_o` && `evt_ready_i`, drop `evt_valid_o` and go to IDLE.
  - Peak throughput is therefore one event per 2 cycles.
- **Overflow clear.** `ovf_clr_i` clears all overflow bits. A set in the same cycle wins.

## Timing
- **Reset values:** `db_level_o`=0, `evt_valid_o`=0, `evt_id_o`=0, `evt_rise_o`=0, `overflow_o`=0. Synchronisers, counters, prescaler and pending slots are all 0. `last`=NumCh-1, so channel 0 has first priority. FSM is in IDLE.
- **Level latency.** A `sw_i` change reaches `sync` after 2 edges. `db_level_o` changes on the edge that closes the StableSamples-th strobe seeing the new `sync` value.
- **Event latency.** `evt_valid_o` rises 1 cycle after the `db_level_o` change, provided the FSM is in IDLE.
- **Handshake.**
  - `evt_valid_o` never drops without a handshake.
  - `evt_id_o` and `evt_rise_o` are stable while valid.
  - `evt_ready_i` is ignored while valid=0.
- **Mid-operation reset.** Asserting `rst_ni` at any point returns everything to reset values immediately, with no clock edge required. Pending and in-flight events are discarded.

## Configuration
- `DEBOUNCE_SCHED_FALL_EN` defined: falling edges pend events with rise=0, as described above.
- Undefined: only rising edges pend events. `db_level_o` still follows falling edges, and `evt_rise_o` is tied to 1.

## Test plan
All scenarios use NumCh=4, ClkFreq=1000, SampleRate=100 (SampleDiv=10), StableSamples=3, en_i=1, and `DEBOUNCE_SCHED_FALL_EN` defined unless stated.

- **Reset.** Hold `rst_ni`=0 with random `sw_i` → all outputs 0. Release → no event until an input is stable for 3 strobes.
- **Single edge.** `sw_i[1]`=1 held → `db_level_o[1]`=1 on the 3rd strobe after sync, then `evt_valid_o`=1 with id=1, rise=1 one cycle later. `evt_ready_i`=1 → valid drops the next cycle.
- **Glitch.** `sw_i[0]` high for 2 strobes, then low → `db_level_o[0]` stays 0, `evt_valid_o` stays 0.
- **Round-robin.**
  - ch0 and ch2 rise on the same strobe, ready=1 → events id0 then id2.
  - Then ch0 and ch3 fall together → events id3 then id0, both with rise=0.
- **Overflow.** ready=0; ch3 rises, falls, rises, each edge held for 3 strobes.
  - Output holds (3,1); `overflow_o[3]`=1.
  - Raising ready → (3,1), then (3,1) again.
  - `ovf_clr_i` pulse → `overflow_o`=0.
- **Macro off, then mid-operation reset.** Without `DEBOUNCE_SCHED_FALL_EN`, a ch2 rise then fall → only the (2,1) event appears, and `db_level_o[2]` returns to 0. Then assert `rst_ni` while `evt_valid_o`=1 → valid drops asynchronously and nothing is replayed after release.

Source files
------------

// File: rtl/debounce_scheduler.sv
// Purpose     : multi-channel switch debouncer. One sample prescaler is shared by all channels,
//               and a round-robin arbiter serialises the debounced edge events onto one port.
// Latency     : sw_i to sync takes 2 cycles. db_level_o changes on the StableSamples-th strobe
//               that sees the new level. evt_valid_o rises 1 cycle later when the arbiter is idle.
// Backpressure: each channel has one pending slot. A newer edge on an ungranted slot overwrites
//               the rise bit and sets the sticky overflow_o bit. Peak rate is 1 event per 2 cycles.
//
// Ports:
//   clk_i, rst_ni         clock; asynchronous active-low reset
//   en_i                  sampling enable (0 holds the prescaler and clears the channel counters)
//   sw_i[NumCh]           raw asynchronous switch inputs
//   db_level_o[NumCh]     debounced levels
//   evt_valid_o / evt_ready_i / evt_id_o / evt_rise_o   event handshake port
//   overflow_o[NumCh]     sticky per-channel overwrite flags
//   ovf_clr_i             clears overflow_o (a set in the same cycle wins)
//
// Optional feature, macro DEBOUNCE_SCHED_FALL_EN:
//   defined   - falling edges also pend events, with evt_rise_o = 0
//   undefined - only rising edges pend events, and evt_rise_o is tied to 1
module debounce_scheduler #(
  parameter int NumCh         = 4,
  parameter int ClkFreq       = 100_000_000,
  parameter int SampleRate    = 1000,
  parameter int StableSamples = 10,
  localparam int IdW          = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [NumCh-1:0] sw_i,
  output logic [NumCh-1:0] db_level_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [IdW-1:0]   evt_id_o,
  output logic             evt_rise_o,
  output logic [NumCh-1:0] overflow_o,
  input  logic             ovf_clr_i
);

  localparam int SampleDiv = ClkFreq / SampleRate;
  localparam int DivW      = (SampleDiv > 1) ? $clog2(SampleDiv) : 1;

  // Elaboration-time parameter checks
  if (SampleDiv < 2) begin : g_bad_div
    $error("debounce_scheduler: ClkFreq/SampleRate must be at least 2");
  end
  if (StableSamples < 1 || StableSamples > 255) begin : g_bad_stable
    $error("debounce_scheduler: StableSamples must be in 1..255");
  end
  if (NumCh < 1 || NumCh > 16) begin : g_bad_numch
    $error("debounce_scheduler: NumCh must be in 1..16");
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [NumCh-1:0] r_sync_q1;
  logic [NumCh-1:0] r_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync_q1 <= '0;
      r_sync    <= '0;
    end else begin
      r_sync_q1 <= sw_i;
      r_sync    <= r_sync_q1;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared sample prescaler: strobe on the last count of each period
  // ---------------------------------------------------------------------------
  logic [DivW-1:0] r_div_cnt;
  logic            w_strobe;

  assign w_strobe = en_i && (r_div_cnt == DivW'(SampleDiv - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_div_cnt <= '0;
    end else if (!en_i || w_strobe) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel stable-sample counters and debounced levels
  // ---------------------------------------------------------------------------
  logic [7:0]       r_stab_cnt [NumCh];
  logic [NumCh-1:0] r_level;
  logic [NumCh-1:0] w_diff;
  logic [NumCh-1:0] w_hit;
  logic [NumCh-1:0] w_new_evt;

  // A hit is the strobe on which the counter would reach StableSamples,
  // so the counter never has to hold the terminal value itself.
  always_comb begin
    w_diff = r_sync ^ r_level;
    w_hit  = '0;
    for (int c = 0; c < NumCh; c++) begin
      w_hit[c] = w_strobe && w_diff[c] && (r_stab_cnt[c] == 8'(StableSamples - 1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumCh; c++) begin
        r_stab_cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NumCh; c++) begin
        if (!en_i) begin
          r_stab_cnt[c] <= '0;
        end else if (w_strobe) begin
          if (!w_diff[c] || w_hit[c]) begin
            r_stab_cnt[c] <= '0;
          end else begin
            r_stab_cnt[c] <= r_stab_cnt[c] + 8'd1;
          end
        end
      end
    end
  end

  // A hit always means sync differs from level, so toggling is the same as loading sync.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_level <= '0;
    end else begin
      r_level <= r_level ^ w_hit;
    end
  end

`ifdef DEBOUNCE_SCHED_FALL_EN
  assign w_new_evt = w_hit;
`else
  assign w_new_evt = w_hit & r_sync;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin pick: first pending channel at or after last+1 (mod NumCh)
  // ---------------------------------------------------------------------------
  logic [NumCh-1:0] r_pend;
  logic [NumCh-1:0] r_ovf;
  logic [IdW-1:0]   r_last;
  state_t           r_state;
  logic             r_evt_vld;
  logic [IdW-1:0]   r_evt_id;

  logic             w_pick_vld;
  logic [IdW-1:0]   w_pick_id;
  logic             w_take;
  logic [NumCh-1:0] w_gnt_oh;
  logic [NumCh-1:0] w_ovf_set;

  function automatic logic [IdW-1:0] f_wrap(input logic [IdW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NumCh;
    return IdW'(s);
  endfunction

  // Scan from the farthest offset down, so the nearest pending channel is the last one written.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_id  = '0;
    for (int k = NumCh; k >= 1; k--) begin
      if (r_pend[f_wrap(r_last, k)]) begin
        w_pick_vld = 1'b1;
        w_pick_id  = f_wrap(r_last, k);
      end
    end
  end

  assign w_take = (r_state == S_IDLE) && w_pick_vld;

  always_comb begin
    w_gnt_oh = '0;
    if (w_take) begin
      w_gnt_oh[w_pick_id] = 1'b1;
    end
  end

  // A slot granted in the same cycle as a new edge is not an overwrite:
  // the old data leaves through the grant, and the new event stays pending.
  assign w_ovf_set = w_new_evt & r_pend & ~w_gnt_oh;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend <= '0;
      r_ovf  <= '0;
    end else begin
      r_pend <= (r_pend & ~w_gnt_oh) | w_new_evt;
      r_ovf  <= (r_ovf & ~{NumCh{ovf_clr_i}}) | w_ovf_set;
    end
  end

`ifdef DEBOUNCE_SCHED_FALL_EN
  logic [NumCh-1:0] r_prise;
  logic             r_evt_rise;

  // The newest edge direction always wins in the slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prise <= '0;
    end else begin
      r_prise <= (r_prise & ~w_new_evt) | (r_sync & w_new_evt);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Output FSM: IDLE loads an event, HOLD keeps it until it is accepted
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_evt_vld <= 1'b0;
      r_evt_id  <= '0;
      r_last    <= IdW'(NumCh - 1);
`ifdef DEBOUNCE_SCHED_FALL_EN
      r_evt_rise <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_evt_id  <= w_pick_id;
            r_last    <= w_pick_id;
            r_evt_vld <= 1'b1;
            r_state   <= S_HOLD;
`ifdef DEBOUNCE_SCHED_FALL_EN
            r_evt_rise <= r_prise[w_pick_id];
`endif
          end
        end
        S_HOLD: begin
          if (evt_ready_i) begin
            r_evt_vld <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_evt_vld <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign db_level_o  = r_level;
  assign evt_valid_o = r_evt_vld;
  assign evt_id_o    = r_evt_id;
  assign overflow_o  = r_ovf;
`ifdef DEBOUNCE_SCHED_FALL_EN
  assign evt_rise_o  = r_evt_rise;
`else
  assign evt_rise_o  = 1'b1;
`endif

endmodule
